// File: rtl/iter_isqrt_if.sv
// Handshake bundle for the iterative integer square root.
// master drives radicands and consumes results; slave is the core.
interface iter_isqrt_if #(
  parameter int N = 23
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] in_radicand;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_root;
  logic [N:0]     out_rem;
  logic           busy;

  modport master (
    output in_valid,
    output in_radicand,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_root,
    input  out_rem,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_radicand,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_root,
    output out_rem,
    output busy
  );
endinterface

// File: rtl/iter_isqrt.sv
// Restoring integer square root, one root bit per cycle, MSB first.
// Fixed N-cycle latency; result registers hold until the next result.
module iter_isqrt #(
  parameter int N = 23
) (
  input  logic      clk,
  input  logic      rst_n,
  iter_isqrt_if.slave io
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [2*N-1:0] rad_q, rad_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_q, q_d;
  logic [N+1:0]   r_q, r_d;
  logic [N-1:0]   root_q, root_d;
  logic [N:0]     rem_q, rem_d;

  logic [N+1:0]   r_sh;
  logic [N+1:0]   t;
  logic [N+1:0]   r_nx;
  logic [N-1:0]   q_nx;
  logic           ge;

  // Partial remainder never exceeds 2q, so its top bits drop out of the shift.
  always_comb begin
    r_sh = {r_q[N-1:0], rad_q[2*N-1 -: 2]};
    t    = {q_q, 2'b01};
    ge   = (r_sh >= t);
    r_nx = ge ? (r_sh - t) : r_sh;
    q_nx = {q_q[N-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    root_d  = root_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          rad_d   = io.in_radicand;
          cnt_d   = CW'(N);
          q_d     = '0;
          r_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rad_d = rad_q << 2;
        cnt_d = cnt_q - CW'(1);
        q_d   = q_nx;
        r_d   = r_nx;
        if (cnt_q == CW'(1)) begin
          root_d  = q_nx;
          rem_d   = r_nx[N:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rad_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);
  assign io.out_root  = root_q;
  assign io.out_rem   = rem_q;
endmodule

// File: tb/tb_iter_isqrt.sv
// Directed and random checks of iter_isqrt against a real-valued sqrt
// model, with a scoreboard queue of expected results.
module tb_iter_isqrt;
  localparam int N = 23;
  localparam int W = 2 * N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iter_isqrt_if #(.N(N)) io();

  iter_isqrt #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  typedef struct {
    logic [63:0] rad;
    logic [63:0] root;
    logic [63:0] rem;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_root(logic [63:0] x);
    logic [63:0] r;
    r = 64'($rtoi($sqrt(real'(x))));
    while (r * r > x) r = r - 1;
    while ((r + 1) * (r + 1) <= x) r = r + 1;
    return r;
  endfunction

  task automatic push(logic [63:0] rad);
    exp_t e;
    e.rad  = rad;
    e.root = ref_root(rad);
    e.rem  = rad - e.root * e.root;
    sb.push_back(e);
  endtask

  task automatic run_one(logic [63:0] rad, int hold, bit inject);
    int   lat;
    exp_t e;
    @(negedge clk);
    chk("in_ready_pre", io.in_ready, 1);
    io.in_valid    = 1'b1;
    io.in_radicand = W'(rad);
    push(rad);
    @(posedge clk);
    #1;
    io.in_valid    = 1'b0;
    io.in_radicand = W'({$urandom, $urandom});
    chk("busy_run", io.busy, 1);
    lat = 0;
    while (!io.out_valid && lat < N + 8) begin
      if (inject && lat == 5) begin
        io.in_valid    = 1'b1;
        io.in_radicand = W'(9);
      end
      @(posedge clk);
      #1;
      lat++;
      if (inject && lat == 6) chk("inject_ready", io.in_ready, 0);
      io.in_valid = 1'b0;
    end
    chk("latency", lat, N);
    if (io.out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("root", io.out_root, e.root);
      chk("rem", io.out_rem, e.rem);
      chk("rem_bound", io.out_rem <= 2 * io.out_root, 1);
      chk("identity", 64'(io.out_root) * 64'(io.out_root)
          + 64'(io.out_rem), e.rad);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_root", io.out_root, e.root);
        chk("hold_rem", io.out_rem, e.rem);
        chk("hold_ready", io.in_ready, 0);
        chk("hold_valid", io.out_valid, 1);
      end
      io.out_ready = 1'b1;
      @(posedge clk);
      #1;
      io.out_ready = 1'b0;
      chk("idle_ready", io.in_ready, 1);
      chk("idle_valid", io.out_valid, 0);
      chk("idle_busy", io.busy, 0);
      chk("retain_root", io.out_root, e.root);
      chk("retain_rem", io.out_rem, e.rem);
    end
  endtask

  initial begin
    int          tq[$];
    int          k;
    bit          seen;
    logic [63:0] r17;

    io.in_valid    = 1'b0;
    io.in_radicand = '0;
    io.out_ready   = 1'b0;
    #12;
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_root", io.out_root, 0);
    chk("rst_rem", io.out_rem, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_one(64'd0, 0, 1'b0);
    run_one(64'd144, 0, 1'b0);
    run_one(64'd150, 0, 1'b0);
    run_one(64'd2, 0, 1'b0);
    run_one((64'd1 << W) - 1, 0, 1'b0);
    run_one(64'd1000000, 50, 1'b0);
    run_one(64'd49, 0, 1'b1);
    chk("sb_empty", sb.size(), 0);

    seen = 1'b0;
    repeat (N + 3) begin
      @(posedge clk);
      #1;
      seen |= io.out_valid;
    end
    chk("no_extra_result", seen, 0);

    @(negedge clk);
    io.in_valid    = 1'b1;
    io.in_radicand = W'(64'd1000000000000);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", io.busy, 0);
    chk("abort_ready", io.in_ready, 1);
    chk("abort_valid", io.out_valid, 0);
    chk("abort_root", io.out_root, 0);
    chk("abort_rem", io.out_rem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (N + 5) begin
      @(posedge clk);
      #1;
      seen |= io.out_valid;
    end
    chk("abort_no_valid", seen, 0);
    run_one(64'd81, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      run_one(64'({$urandom, $urandom}) & ((64'd1 << W) - 1), i, 1'b0);
    end

    r17 = ref_root(64'd17);
    @(negedge clk);
    io.in_valid    = 1'b1;
    io.in_radicand = W'(17);
    io.out_ready   = 1'b1;
    for (int j = 0; j < 3 * (N + 2) + 4; j++) begin
      @(posedge clk);
      #1;
      if (io.out_valid) begin
        tq.push_back(j);
        chk("tput_root", io.out_root, r17);
        chk("tput_rem", io.out_rem, 64'd17 - r17 * r17);
      end
    end
    io.in_valid = 1'b0;
    chk("tput_count", tq.size() >= 2, 1);
    if (tq.size() >= 2) begin
      chk("tput_first", tq[0], N);
      chk("tput_gap", tq[1] - tq[0], N + 2);
    end
    k = 0;
    while (!io.in_ready && k < N + 5) begin
      @(posedge clk);
      #1;
      k++;
    end
    io.out_ready = 1'b0;
    chk("drain_ready", io.in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_isqrt.md
ITER_ISQRT -- requirements
Module: iter_isqrt

Interface
REQ-001 Parameter: N, default 23, root width in bits; radicand width is 2N bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  radicand offered.
REQ-005 in_ready  output  1  block can accept a radicand.
REQ-006 in_radicand  input  2N  unsigned radicand.
REQ-007 out_valid  output  1  result available.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 out_root  output  N  floor(sqrt(radicand)).
REQ-010 out_rem  output  N+1  radicand - root*root.
REQ-011 busy  output  1  high in RUN or DONE state.

Function
REQ-012 FSM states SHALL be IDLE, RUN, DONE; no other states reachable.
REQ-013 in_ready SHALL equal 1 only in IDLE; out_valid SHALL equal 1 only in DONE.
REQ-014 Input handshake = in_valid && in_ready at a rising edge; radicand captured on that edge, iteration counter loaded with N, partial root and partial remainder cleared, state -> RUN.
REQ-015 in_valid while not in IDLE SHALL be ignored; in_radicand changes outside the handshake edge SHALL not affect the result.
REQ-016 Each RUN edge SHALL produce exactly one root bit, MSB first: r' = (r << 2) | top two unconsumed radicand bits; t = (q << 2) | 1; if r' >= t then r = r' - t, q = (q << 1) | 1, else r = r', q = q << 1; radicand shifted left by 2.
REQ-017 Partial remainder register SHALL be N+2 bits wide; comparison and subtraction unsigned, no truncation loss.
REQ-018 After the N-th RUN edge, state -> DONE; out_valid SHALL rise exactly N edges after the accepting edge, for every radicand value (fixed latency, no early exit).
REQ-019 In DONE, out_root and out_rem SHALL hold stable while out_ready = 0 (backpressure of any length).
REQ-020 Output handshake = out_valid && out_ready at a rising edge; state -> IDLE on that edge; in_ready high the following cycle.
REQ-021 out_root and out_rem SHALL retain the last result in IDLE and RUN until the next DONE; they are only guaranteed meaningful while out_valid = 1.
REQ-022 out_rem SHALL always satisfy out_rem <= 2*out_root; out_root*out_root + out_rem SHALL equal the captured radicand.
REQ-023 Radicand 0 and radicand 2^(2N)-1 SHALL be handled with no overflow and the same latency.
REQ-024 Throughput: one result per N+2 cycles maximum with in_valid and out_ready held high.

Reset
REQ-025 While rst_n = 0: state IDLE, in_ready = 1, out_valid = 0, busy = 0, out_root = 0, out_rem = 0, counter and datapath registers 0.
REQ-026 Reset assertion mid-RUN or in DONE SHALL abandon the operation immediately (asynchronously); no out_valid pulse for the abandoned radicand.
REQ-027 First input handshake SHALL be possible on the first rising edge after rst_n deasserts.

Verification (N = 23)
REQ-028 Radicand 0 -> out_valid 23 edges after accept, root 0, rem 0.
REQ-029 Radicand 144 -> root 12, rem 0; radicand 150 -> root 12, rem 6; radicand 2 -> root 1, rem 1.
REQ-030 Radicand 2^46-1 -> root 8388607, rem 16777214.
REQ-031 Radicand 1000000, out_ready held 0 for 50 cycles -> root 1000, rem 0 stable throughout, in_ready 0 throughout, IDLE one edge after out_ready = 1.
REQ-032 Second in_valid pulse (radicand 9) during RUN of radicand 49 -> single result root 7 rem 0; the 9 is not accepted.
REQ-033 rst_n pulsed low at iteration 10 of radicand 10^12 -> out_valid never rises for it; subsequent radicand 81 -> root 9, rem 0.
